serdes_framed_core: RTL and testbench

- Parametrised serializer/deserializer core. It supersedes the fixed 10-bit PISO/SIPO pair used behind the 8b/10b codec.
- TX side: a continuous bit stream. Words are accepted via valid/ready. When no data is offered, SYNC_WORD filler is sent.
- RX side: hunts for SYNC_WORD, locks word alignment after LOCK_CNT consecutive aligned hits, then delivers non-sync words with a valid pulse.
- Sits between the encoder/decoder latches and the pad; adds internal loopback for self-test.

---
 rtl/serdes_pkg.sv | 16 +
 rtl/serdes_word_aligner.sv | 111 +++++++++++
 rtl/serdes_framed_core.sv | 77 +++++++
 tb/tb_serdes_framed_core.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared types and constants for the framed SERDES core.
package serdes_pkg;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } rx_state_t;

    localparam logic [9:0] K28_5_RDN = 10'h0FA;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serdes_word_aligner.sv
// RX word alignment: sliding window, sync hunt/verify/lock FSM and word delivery.
module serdes_word_aligner
    import serdes_pkg::*;
#(
    parameter int unsigned        WORD_W    = 10,
    parameter bit                 LSB_FIRST = 1'b1,
    parameter logic [WORD_W-1:0]  SYNC_WORD = WORD_W'(K28_5_RDN),
    parameter int unsigned        LOCK_CNT  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_bit,
    input  logic              resync,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_locked
);

    localparam int unsigned     CW        = cnt_width(WORD_W);
    localparam logic [CW-1:0]   LAST      = CW'(WORD_W - 1);
    localparam logic [3:0]      LOCK_HITS = 4'(LOCK_CNT);

    rx_state_t         state, state_nx;
    logic [WORD_W-1:0] window, nwin;
    logic [CW-1:0]     rx_cnt, rx_cnt_nx;
    logic [3:0]        hit, hit_nx;
    logic              valid_nx;
    logic              match;
    logic              at_last;

    always_comb begin
        nwin = window;
        if (LSB_FIRST) begin
            nwin = {rx_bit, window[WORD_W-1:1]};
        end else begin
            nwin = {window[WORD_W-2:0], rx_bit};
        end
    end

    assign match   = (nwin == SYNC_WORD);
    assign at_last = (rx_cnt == LAST);

    always_comb begin
        state_nx  = state;
        rx_cnt_nx = rx_cnt;
        hit_nx    = hit;
        valid_nx  = 1'b0;
        case (state)
            HUNT: begin
                rx_cnt_nx = '0;
                if (match) begin
                    hit_nx   = 4'd1;
                    state_nx = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                rx_cnt_nx = at_last ? '0 : rx_cnt + 1'b1;
                if (at_last) begin
                    if (match) begin
                        hit_nx = hit + 1'b1;
                        if (hit_nx == LOCK_HITS) begin
                            state_nx = LOCKED;
                        end
                    end else begin
                        hit_nx   = '0;
                        state_nx = HUNT;
                    end
                end
            end
            LOCKED: begin
                rx_cnt_nx = at_last ? '0 : rx_cnt + 1'b1;
                // Sync words on the boundary are filler and never delivered.
                if (at_last && !match) begin
                    valid_nx = 1'b1;
                end
            end
            default: begin
                state_nx = HUNT;
            end
        endcase
        if (resync) begin
            state_nx  = HUNT;
            rx_cnt_nx = '0;
            hit_nx    = '0;
            valid_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            window    <= '0;
            rx_cnt    <= '0;
            hit       <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_locked <= 1'b0;
        end else begin
            state     <= state_nx;
            window    <= nwin;
            rx_cnt    <= rx_cnt_nx;
            hit       <= hit_nx;
            rx_valid  <= valid_nx;
            rx_locked <= (state_nx == LOCKED);
            if (valid_nx) begin
                rx_data <= nwin;
            end
        end
    end

endmodule

// File: rtl/serdes_framed_core.sv
// Framed serializer/deserializer: continuous TX with sync filler, aligned RX, loopback.
module serdes_framed_core
    import serdes_pkg::*;
#(
    parameter int unsigned        WORD_W    = 10,
    parameter bit                 LSB_FIRST = 1'b1,
    parameter logic [WORD_W-1:0]  SYNC_WORD = WORD_W'(K28_5_RDN),
    parameter int unsigned        LOCK_CNT  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              ser_out,
    input  logic              ser_in,
    input  logic              loopback,
    input  logic              resync,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_locked
);

    localparam int unsigned   CW   = cnt_width(WORD_W);
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

    logic [CW-1:0]     tx_cnt;
    logic [WORD_W-1:0] tx_shift;
    logic [WORD_W-1:0] tx_src;
    logic              rx_bit;

    assign tx_ready = (tx_cnt == LAST);

    // On a boundary the freshly loaded word drives ser_out directly, so its
    // first bit leaves in the next cycle and words abut with no gap.
    always_comb begin
        tx_src = tx_shift;
        if (tx_ready) begin
            tx_src = tx_valid ? tx_data : SYNC_WORD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt   <= LAST;
            tx_shift <= '0;
            ser_out  <= 1'b0;
        end else begin
            tx_cnt <= tx_ready ? '0 : tx_cnt + 1'b1;
            if (LSB_FIRST) begin
                ser_out  <= tx_src[0];
                tx_shift <= tx_src >> 1;
            end else begin
                ser_out  <= tx_src[WORD_W-1];
                tx_shift <= tx_src << 1;
            end
        end
    end

    assign rx_bit = loopback ? ser_out : ser_in;

    serdes_word_aligner #(
        .WORD_W    (WORD_W),
        .LSB_FIRST (LSB_FIRST),
        .SYNC_WORD (SYNC_WORD),
        .LOCK_CNT  (LOCK_CNT)
    ) u_aligner (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_bit    (rx_bit),
        .resync    (resync),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_locked (rx_locked)
    );

endmodule

// File: tb/tb_serdes_framed_core.sv
// Directed self-checking bench for serdes_framed_core (WORD_W=10, LSB first, LOCK_CNT=3).
module tb_serdes_framed_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ser_out;
    logic       ser_in;
    logic       loopback;
    logic       resync;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       rx_locked;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    logic [9:0] sync_v = 10'h0FA;

    serdes_framed_core #(
        .WORD_W    (10),
        .LSB_FIRST (1'b1),
        .SYNC_WORD (10'h0FA),
        .LOCK_CNT  (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ser_out   (ser_out),
        .ser_in    (ser_in),
        .loopback  (loopback),
        .resync    (resync),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_locked (rx_locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && rx_valid) pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_in = b;
        tick();
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit(w[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        ser_in   = 1'b0;
        loopback = 1'b1;
        resync   = 1'b0;
        repeat (3) tick();
        check_eq("rst_ser_out",   ser_out,   0);
        check_eq("rst_rx_data",   rx_data,   0);
        check_eq("rst_rx_valid",  rx_valid,  0);
        check_eq("rst_rx_locked", rx_locked, 0);
        check_eq("rst_tx_ready",  tx_ready,  1);
        #3 rst_n = 1'b1;

        // Idle loopback: sync filler LSB first, boundary every 10 edges.
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_eq("idle_ser_bit",  ser_out,  sync_v[e-1]);
            check_eq("idle_tx_ready", tx_ready, (e == 10) ? 1 : 0);
        end
        repeat (20) tick();                              // edge 30
        check_eq("lock_pre",  rx_locked, 0);
        tick();                                          // edge 31
        check_eq("lock_idle", rx_locked, 1);
        check_eq("idle_no_valid", pulses, 0);

        // Data word in loopback, accepted at edge 41 and 51.
        tx_data  = 10'h2A5;
        tx_valid = 1'b1;
        repeat (8) tick();                               // edge 39
        check_eq("rdy_39", tx_ready, 0);
        tick();                                          // edge 40
        check_eq("rdy_40", tx_ready, 1);
        tick();                                          // edge 41
        check_eq("rdy_41", tx_ready, 0);
        repeat (9) tick();                               // edge 50
        check_eq("valid_50", rx_valid, 0);
        check_eq("rdy_50", tx_ready, 1);
        tick();                                          // edge 51
        tx_valid = 1'b0;
        check_eq("valid_51", rx_valid, 1);
        check_eq("data_51",  rx_data,  10'h2A5);
        tick();                                          // edge 52
        check_eq("valid_52", rx_valid, 0);
        check_eq("hold_52",  rx_data,  10'h2A5);
        repeat (9) tick();                               // edge 61
        check_eq("valid_61", rx_valid, 1);
        repeat (10) tick();                              // edge 71
        check_eq("valid_71", rx_valid, 0);
        check_eq("pulses_71", pulses, 2);

        // Resync coinciding with a data boundary.
        repeat (9) tick();                               // edge 80
        tx_data  = 10'h1C3;
        tx_valid = 1'b1;
        tick();                                          // edge 81
        tx_valid = 1'b0;
        repeat (9) tick();                               // edge 90
        resync = 1'b1;
        tick();                                          // edge 91
        resync = 1'b0;
        check_eq("resync_valid",  rx_valid,  0);
        check_eq("resync_locked", rx_locked, 0);
        check_eq("resync_hold",   rx_data,   10'h2A5);
        repeat (29) tick();                              // edge 120
        check_eq("relock_pre", rx_locked, 0);
        tick();                                          // edge 121
        check_eq("relock", rx_locked, 1);
        check_eq("pulses_121", pulses, 2);

        // External input with 3-bit junk offset.
        repeat (9) tick();                               // edge 130
        loopback = 1'b0;
        ser_in   = 1'b0;
        resync   = 1'b1;
        tick();                                          // edge 131
        resync = 1'b0;
        check_eq("ext_unlock", rx_locked, 0);
        send_word(10'h000);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_word(10'h0FA);
        send_word(10'h0FA);
        check_eq("ext_lock_pre", rx_locked, 0);
        send_word(10'h0FA);
        check_eq("ext_lock", rx_locked, 1);
        send_word(10'h155);
        check_eq("ext_valid", rx_valid, 1);
        check_eq("ext_data",  rx_data,  10'h155);

        // Corrupted sync during VERIFY falls back to HUNT.
        ser_in = 1'b0;
        resync = 1'b1;
        tick();
        resync = 1'b0;
        send_word(10'h000);
        send_word(10'h0FA);
        send_word(10'h0FB);
        check_eq("verify_fail", rx_locked, 0);
        send_word(10'h0FA);
        send_word(10'h0FA);
        check_eq("verify_relock_pre", rx_locked, 0);
        send_word(10'h0FA);
        check_eq("verify_relock", rx_locked, 1);

        // Asynchronous reset in the middle of an all-ones word.
        loopback = 1'b1;
        for (int i = 0; i < 12 && !tx_ready; i++) tick();
        check_eq("tx_ready_wait", tx_ready, 1);
        tx_data  = 10'h3FF;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check_eq("word3ff_bit0", ser_out, 1);
        check_eq("word3ff_rdy",  tx_ready, 0);
        repeat (3) tick();
        check_eq("word3ff_mid",  ser_out, 1);
        check_eq("pre_rst_lock", rx_locked, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_ser_out", ser_out,   0);
        check_eq("arst_locked",  rx_locked, 0);
        check_eq("arst_valid",   rx_valid,  0);
        check_eq("arst_data",    rx_data,   0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        check_eq("rel_tx_ready", tx_ready, 1);
        tick();
        check_eq("rel_e1_ready", tx_ready, 0);
        check_eq("rel_e1_bit",   ser_out,  0);
        repeat (8) tick();
        check_eq("rel_e9_ready", tx_ready, 0);
        tick();
        check_eq("rel_e10_ready", tx_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
